// File: rtl/video_rgb2ycbcr_cfg.sv
// RGB -> YCbCr converter with per-frame selectable BT.601/BT.709 coefficients,
// rounding, range clamping and optional co-sited 4:2:2 chroma output.
module video_rgb2ycbcr_cfg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cfg_std,
  input  logic          cfg_422,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_red,
  input  logic [DW-1:0] per_img_green,
  input  logic [DW-1:0] per_img_blue,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [DW-1:0] post_img_Y,
  output logic [DW-1:0] post_img_C0,
  output logic [DW-1:0] post_img_C1,
  output logic          post_chroma_sel
);

  localparam int LAT = 4;
  localparam int SW  = DW + 11;
  localparam int SC  = DW - 8;

  localparam logic signed [SW-1:0] OFF_Y = SW'(16 << DW);
  localparam logic signed [SW-1:0] OFF_C = SW'(128 << DW);
  localparam logic signed [SW-1:0] RND   = SW'(128);
  localparam logic signed [SW-1:0] LIM_LO   = SW'(16 << SC);
  localparam logic signed [SW-1:0] LIM_Y_HI = SW'(235 << SC);
  localparam logic signed [SW-1:0] LIM_C_HI = SW'(240 << SC);
  localparam logic signed [SW-1:0] LIM_MAX  = SW'((1 << DW) - 1);

  // Rows: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); index 3 (reserved) aliases BT.601 studio.
  localparam logic signed [9:0] COEF [4][9] = '{
    '{10'sd66, 10'sd129, 10'sd25, -10'sd38, -10'sd74, 10'sd112, 10'sd112, -10'sd94, -10'sd18},
    '{10'sd77, 10'sd150, 10'sd29, -10'sd43, -10'sd85, 10'sd128, 10'sd128, -10'sd107, -10'sd21},
    '{10'sd47, 10'sd157, 10'sd16, -10'sd26, -10'sd87, 10'sd112, 10'sd112, -10'sd102, -10'sd10},
    '{10'sd66, 10'sd129, 10'sd25, -10'sd38, -10'sd74, 10'sd112, 10'sd112, -10'sd94, -10'sd18}
  };

  function automatic logic signed [SW-1:0] mul(input logic [DW-1:0] x, input logic signed [9:0] k);
    logic signed [SW-1:0] xs;
    logic signed [SW-1:0] ks;
    xs = $signed({{(SW-DW){1'b0}}, x});
    ks = {{(SW-10){k[9]}}, k};
    return xs * ks;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v,
                                          input logic signed [SW-1:0] lo,
                                          input logic signed [SW-1:0] hi);
    if (v < lo) return lo[DW-1:0];
    if (v > hi) return hi[DW-1:0];
    return v[DW-1:0];
  endfunction

  // Config shadowing: a vsync rise in this cycle already applies to this cycle's pixel.
  logic       vsync_d;
  logic [1:0] sh_std;
  logic       sh_422;
  logic       vs_rise;
  logic [1:0] std_in;
  logic [1:0] std_eff;
  logic       m422_eff;

  always_comb begin
    vs_rise  = per_frame_vsync & ~vsync_d;
    std_in   = (cfg_std == 2'd3) ? 2'd0 : cfg_std;
    std_eff  = vs_rise ? std_in : sh_std;
    m422_eff = vs_rise ? cfg_422 : sh_422;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      sh_std  <= 2'd0;
      sh_422  <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      if (vs_rise) begin
        sh_std <= std_in;
        sh_422 <= cfg_422;
      end
    end
  end

  // Sync shift registers
  logic [LAT-1:0] vs_sr, hr_sr, ce_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr <= '0;
      hr_sr <= '0;
      ce_sr <= '0;
    end else begin
      vs_sr <= {vs_sr[LAT-2:0], per_frame_vsync};
      hr_sr <= {hr_sr[LAT-2:0], per_frame_href};
      ce_sr <= {ce_sr[LAT-2:0], per_frame_clken};
    end
  end

  // Stage 1: products
  logic [DW-1:0]        rgb [3];
  logic signed [SW-1:0] p1 [9];
  logic [1:0]           std1;
  logic                 m1;

  always_comb begin
    rgb[0] = per_img_red;
    rgb[1] = per_img_green;
    rgb[2] = per_img_blue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) p1[i] <= '0;
      std1 <= 2'd0;
      m1   <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) p1[i] <= mul(rgb[i % 3], COEF[std_eff][i]);
      std1 <= std_eff;
      m1   <= m422_eff;
    end
  end

  // Stage 2: sums with offset and rounding constant
  logic signed [SW-1:0] s2 [3];
  logic signed [SW-1:0] off_y;
  logic [1:0]           std2;
  logic                 m2;

  always_comb off_y = (std1 == 2'd1) ? '0 : OFF_Y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) s2[i] <= '0;
      std2 <= 2'd0;
      m2   <= 1'b0;
    end else begin
      s2[0] <= p1[0] + p1[1] + p1[2] + off_y + RND;
      s2[1] <= p1[3] + p1[4] + p1[5] + OFF_C + RND;
      s2[2] <= p1[6] + p1[7] + p1[8] + OFF_C + RND;
      std2  <= std1;
      m2    <= m1;
    end
  end

  // Stage 3: shift and clamp
  logic signed [SW-1:0] v_y, v_cb, v_cr;
  logic signed [SW-1:0] lo, y_hi, c_hi;
  logic [DW-1:0]        y3, cb3, cr3;
  logic                 m3;

  always_comb begin
    v_y  = s2[0] >>> 8;
    v_cb = s2[1] >>> 8;
    v_cr = s2[2] >>> 8;
    lo   = (std2 == 2'd1) ? '0 : LIM_LO;
    y_hi = (std2 == 2'd1) ? LIM_MAX : LIM_Y_HI;
    c_hi = (std2 == 2'd1) ? LIM_MAX : LIM_C_HI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y3  <= '0;
      cb3 <= '0;
      cr3 <= '0;
      m3  <= 1'b0;
    end else begin
      y3  <= clamp(v_y, lo, y_hi);
      cb3 <= clamp(v_cb, lo, c_hi);
      cr3 <= clamp(v_cr, lo, c_hi);
      m3  <= m2;
    end
  end

  // Stage 4: chroma selection; parity restarts at each delayed-href rise.
  logic          href4, clken4, href_prev;
  logic          parity, par_now;
  logic [DW-1:0] held_cr;
  logic [DW-1:0] y_o, c0_o, c1_o;
  logic          sel_o;

  always_comb begin
    href4     = hr_sr[LAT-2];
    clken4    = ce_sr[LAT-2];
    href_prev = hr_sr[LAT-1];
    par_now   = href_prev & parity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_o     <= '0;
      c0_o    <= '0;
      c1_o    <= '0;
      sel_o   <= 1'b0;
      parity  <= 1'b0;
      held_cr <= '0;
    end else if (!href4) begin
      y_o     <= '0;
      c0_o    <= '0;
      c1_o    <= '0;
      sel_o   <= 1'b0;
      parity  <= 1'b0;
      held_cr <= '0;
    end else if (clken4) begin
      y_o    <= y3;
      parity <= ~par_now;
      if (m3) begin
        c1_o <= '0;
        if (par_now) begin
          c0_o  <= held_cr;
          sel_o <= 1'b1;
        end else begin
          c0_o    <= cb3;
          sel_o   <= 1'b0;
          held_cr <= cr3;
        end
      end else begin
        c0_o  <= cb3;
        c1_o  <= cr3;
        sel_o <= 1'b0;
      end
    end else if (!href_prev) begin
      parity <= 1'b0;
    end
  end

  always_comb begin
    post_frame_vsync = vs_sr[LAT-1];
    post_frame_href  = hr_sr[LAT-1];
    post_frame_clken = ce_sr[LAT-1];
    post_img_Y       = y_o;
    post_img_C0      = c0_o;
    post_img_C1      = c1_o;
    post_chroma_sel  = sel_o;
  end

endmodule
